// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control sequencer for the ALU datapath.
//
// Holds a 16-bit instruction register and steps a Moore FSM that issues
// register-file reads/writes, operand loads, ALU op select and result/status
// loads for MOV imm, MOV reg, ADD, CMP, AND and MVN. Every control output is
// taken from a register that is loaded with the Moore decode of the *next*
// state, so outputs are glitch-free yet cycle-identical to a plain Moore decode.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   s, w              start request (sampled in WAIT) / idle indicator
//   load, in          capture instruction word into IR (honoured only in WAIT)
//   rnum, write, vsel register-file index, write strobe, write-data select
//   loada/b/c, loads  operand A/B, result C and status register loads
//   asel, bsel        ALU A-input zero force; bsel is reserved and always 0
//   ALUop, shift      ALU operation and B-shifter control (EXEC only)
//   sximm8            IR[7:0] sign-extended (combinational from IR)
//   err               illegal-instruction flag
//
// Build option: define ALU_SEQ_ILLEGAL_EN to make err latch on an illegal
// decode; otherwise err is held at 0.
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  rnum,
    output logic        write,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic        err
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        K_MOVI = 3'd0,
        K_MOVR = 3'd1,
        K_ADD  = 3'd2,
        K_CMP  = 3'd3,
        K_AND  = 3'd4,
        K_MVN  = 3'd5,
        K_ILL  = 3'd6
    } kind_t;

    typedef struct packed {
        logic       w;
        logic [2:0] rnum;
        logic       write;
        logic       vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] aluop;
        logic [1:0] shift;
    } outs_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        err_q, err_d;
    outs_t       outs_q, outs_d;

    // Classify an instruction word from its opcode and op fields.
    function automatic kind_t decode_kind(input logic [15:0] ir);
        kind_t k;
        case ({ir[15:13], ir[12:11]})
            5'b110_10: k = K_MOVI;
            5'b110_00: k = K_MOVR;
            5'b101_00: k = K_ADD;
            5'b101_01: k = K_CMP;
            5'b101_10: k = K_AND;
            5'b101_11: k = K_MVN;
            default:   k = K_ILL;
        endcase
        return k;
    endfunction

    // Moore output decode for a given state and instruction word.
    function automatic outs_t moore_out(input state_t st, input logic [15:0] ir);
        outs_t o;
        kind_t k;
        o = '0;
        k = decode_kind(ir);
        case (st)
            S_WAIT:   o.w = 1'b1;
            S_DECODE: o.w = 1'b0;
            S_GET_A: begin
                o.rnum  = ir[10:8];
                o.loada = 1'b1;
            end
            S_GET_B: begin
                o.rnum  = ir[2:0];
                o.loadb = 1'b1;
            end
            S_EXEC: begin
                o.shift = ir[4:3];
                o.asel  = (k == K_MOVR) ? 1'b1 : 1'b0;
                case (k)
                    K_CMP: begin
                        o.aluop = 2'b01;
                        o.loads = 1'b1;
                    end
                    K_AND: begin
                        o.aluop = 2'b10;
                        o.loadc = 1'b1;
                    end
                    K_MVN: begin
                        o.aluop = 2'b11;
                        o.loadc = 1'b1;
                    end
                    default: begin
                        // MOV reg and ADD both use the adder (A forced to 0 for MOV)
                        o.aluop = 2'b00;
                        o.loadc = 1'b1;
                    end
                endcase
            end
            S_WR_REG: begin
                o.rnum  = ir[7:5];
                o.write = 1'b1;
            end
            S_WR_IMM: begin
                o.rnum  = ir[10:8];
                o.vsel  = 1'b1;
                o.write = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Next-state, IR capture, error flag and next-output computation.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
`ifdef ALU_SEQ_ILLEGAL_EN
        err_d   = err_q;
`else
        err_d   = 1'b0;
`endif
        case (state_q)
            S_WAIT: begin
                if (load) begin
                    ir_d = in;
                end else begin
                    ir_d = ir_q;
                end
                if (s) begin
                    state_d = S_DECODE;
`ifdef ALU_SEQ_ILLEGAL_EN
                    err_d   = 1'b0;
`endif
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DECODE: begin
                case (decode_kind(ir_q))
                    K_MOVI:               state_d = S_WR_IMM;
                    K_MOVR, K_MVN:        state_d = S_GET_B;
                    K_ADD, K_CMP, K_AND:  state_d = S_GET_A;
                    default: begin
                        state_d = S_WAIT;
`ifdef ALU_SEQ_ILLEGAL_EN
                        err_d   = 1'b1;
`endif
                    end
                endcase
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            S_EXEC: begin
                if (decode_kind(ir_q) == K_CMP) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_WR_REG;
                end
            end
            S_WR_REG: state_d = S_WAIT;
            S_WR_IMM: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
        // Register the decode of the upcoming state so outputs line up with it.
        outs_d = moore_out(state_d, ir_d);
    end

    // State, IR, error flag and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
            err_q   <= 1'b0;
            outs_q  <= moore_out(S_WAIT, 16'h0000);
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
            outs_q  <= outs_d;
        end
    end

    assign w      = outs_q.w;
    assign rnum   = outs_q.rnum;
    assign write  = outs_q.write;
    assign vsel   = outs_q.vsel;
    assign loada  = outs_q.loada;
    assign loadb  = outs_q.loadb;
    assign loadc  = outs_q.loadc;
    assign loads  = outs_q.loads;
    assign asel   = outs_q.asel;
    assign bsel   = outs_q.bsel;
    assign ALUop  = outs_q.aluop;
    assign shift  = outs_q.shift;
    assign err    = err_q;
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a table of instructions with
// hand-computed latency/write expectations, hand-written multi-cycle corner
// sequences, and randomized instructions checked cycle by cycle against a
// trace model built from the instruction's meaning.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset, s, load;
    logic [15:0] in;
    logic        w, write, vsel, loada, loadb, loadc, loads, asel, bsel, err;
    logic [2:0]  rnum;
    logic [1:0]  ALUop, shift;
    logic [15:0] sximm8;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .w(w), .rnum(rnum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .ALUop(ALUop), .shift(shift),
        .sximm8(sximm8), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic [2:0] rnum;
        logic       write;
        logic       vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] aluop;
        logic [1:0] shift;
    } exp_t;
    typedef exp_t trace_t[$];

    typedef struct {
        logic [15:0] word;
        int          lat;
        int          writes;
        logic [2:0]  wr_rnum;
    } vec_t;

    logic [15:0] dut_vec;
    assign dut_vec = {w, rnum, write, vsel, loada, loadb, loadc, loads, asel, bsel, ALUop, shift};

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] ir_model = 16'h0000;
    logic        err_exp  = 1'b0;
    exp_t        idle_rec;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic string mnemonic(input logic [15:0] word);
        if (word[15:13] == 3'b110 && word[12:11] == 2'b10) return "MOVI";
        if (word[15:13] == 3'b110 && word[12:11] == 2'b00) return "MOVR";
        if (word[15:13] == 3'b101 && word[12:11] == 2'b00) return "ADD";
        if (word[15:13] == 3'b101 && word[12:11] == 2'b01) return "CMP";
        if (word[15:13] == 3'b101 && word[12:11] == 2'b10) return "AND";
        if (word[15:13] == 3'b101 && word[12:11] == 2'b11) return "MVN";
        return "ILL";
    endfunction

    function automatic logic [15:0] sext8(input logic [15:0] word);
        int v;
        v = int'(word[7:0]);
        if (v > 127) v = v - 256;
        return v[15:0];
    endfunction

    // Expected per-cycle outputs from DECODE through the return to idle.
    function automatic trace_t model_trace(input logic [15:0] word);
        trace_t t;
        exp_t   r;
        string  mn;
        mn = mnemonic(word);
        r = '0;
        t.push_back(r);
        if (mn == "MOVI") begin
            r = '0; r.rnum = word[10:8]; r.vsel = 1'b1; r.write = 1'b1;
            t.push_back(r);
        end else if (mn != "ILL") begin
            if (mn == "ADD" || mn == "CMP" || mn == "AND") begin
                r = '0; r.rnum = word[10:8]; r.loada = 1'b1;
                t.push_back(r);
            end
            r = '0; r.rnum = word[2:0]; r.loadb = 1'b1;
            t.push_back(r);
            r = '0; r.shift = word[4:3];
            r.asel = (mn == "MOVR");
            if (mn == "CMP") r.aluop = 2'd1;
            else if (mn == "AND") r.aluop = 2'd2;
            else if (mn == "MVN") r.aluop = 2'd3;
            else r.aluop = 2'd0;
            if (mn == "CMP") r.loads = 1'b1;
            else r.loadc = 1'b1;
            t.push_back(r);
            if (mn != "CMP") begin
                r = '0; r.rnum = word[7:5]; r.write = 1'b1;
                t.push_back(r);
            end
        end
        r = '0; r.w = 1'b1;
        t.push_back(r);
        return t;
    endfunction

    function automatic logic err_after(input logic [15:0] word);
`ifdef ALU_SEQ_ILLEGAL_EN
        return (mnemonic(word) == "ILL");
`else
        return 1'b0;
`endif
    endfunction

    // Start one instruction from WAIT and check every cycle until idle again.
    task automatic exec_instr(input string tag, input logic [15:0] word, input bit do_load);
        trace_t tr;
        if (do_load) begin
            in = word;
            ir_model = word;
        end
        load = do_load;
        s = 1'b1;
        tick();
        load = 1'b0;
        s = 1'b0;
        check({tag, " err cleared"}, 32'(err), 32'd0);
        tr = model_trace(ir_model);
        for (int k = 0; k < tr.size(); k++) begin
            if (k > 0) tick();
            check($sformatf("%s cyc%0d", tag, k + 1), 32'(dut_vec), 32'(tr[k]));
        end
        err_exp = err_after(ir_model);
        check({tag, " err"}, 32'(err), 32'(err_exp));
        check({tag, " sximm8"}, 32'(sximm8), 32'(sext8(ir_model)));
    endtask

    // Start one instruction and measure latency and write strobes.
    task automatic measure(input vec_t v);
        int         c;
        int         wr;
        logic [2:0] rn;
        in = v.word;
        ir_model = v.word;
        load = 1'b1;
        s = 1'b1;
        tick();
        load = 1'b0;
        s = 1'b0;
        c = 1;
        wr = 0;
        rn = 3'd0;
        while (w !== 1'b1 && c < 20) begin
            if (write === 1'b1) begin
                wr++;
                rn = rnum;
            end
            tick();
            c++;
        end
        check($sformatf("lat %h", v.word), 32'(c), 32'(v.lat));
        check($sformatf("writes %h", v.word), 32'(wr), 32'(v.writes));
        if (v.writes > 0) check($sformatf("wr rnum %h", v.word), 32'(rn), 32'(v.wr_rnum));
        err_exp = err_after(v.word);
    endtask

    initial begin
        vec_t        vecs[9];
        trace_t      tr;
        int          wcount;
        logic [15:0] word;
        logic [2:0]  opc;
        int          r;

        idle_rec = '0;
        idle_rec.w = 1'b1;

        vecs[0] = '{16'hD2F6, 3, 1, 3'd2};
        vecs[1] = '{16'hA0E9, 6, 1, 3'd7};
        vecs[2] = '{16'hA902, 5, 0, 3'd0};
        vecs[3] = '{16'hB8A3, 5, 1, 3'd5};
        vecs[4] = '{16'h0000, 2, 0, 3'd0};
        vecs[5] = '{16'hC093, 5, 1, 3'd4};
        vecs[6] = '{16'hB3DD, 6, 1, 3'd6};
        vecs[7] = '{16'hE000, 2, 0, 3'd0};
        vecs[8] = '{16'hC800, 2, 0, 3'd0};

        // Reset, then idle for 10 cycles.
        reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
        tick();
        check("reset outs", 32'(dut_vec), 32'(idle_rec));
        check("reset err", 32'(err), 32'd0);
        check("reset sximm8", 32'(sximm8), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("idle %0d", i), 32'(dut_vec), 32'(idle_rec));
        end

        // Table of instructions: latency, write count and write target.
        foreach (vecs[i]) measure(vecs[i]);

        // MOV R2,#-10 with load and s in the same cycle.
        exec_instr("movi", 16'hD2F6, 1'b1);
        check("movi sximm8 const", 32'(sximm8), 32'h0000FFF6);

        // Reset asserted during EXEC of ADD aborts before the write.
        in = 16'hA0E9; load = 1'b1; s = 1'b1;
        tick();
        load = 1'b0; s = 1'b0;
        tick();
        check("add getA rnum", 32'(rnum), 32'd0);
        tick();
        check("add getB rnum", 32'(rnum), 32'd1);
        tick();
        check("add exec", 32'({loadc, ALUop, shift}), 32'(5'b1_00_01));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ir_model = 16'h0000;
        err_exp = 1'b0;
        check("abort idle", 32'(dut_vec), 32'(idle_rec));
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("abort no write %0d", i), 32'(dut_vec), 32'(idle_rec));
        end

        // MVN R5,R3 with s held: one idle cycle between back-to-back runs,
        // and a load pulse mid-execution is ignored.
        in = 16'hB8A3; ir_model = 16'hB8A3; load = 1'b1; s = 1'b1;
        tick();
        load = 1'b0;
        tr = model_trace(16'hB8A3);
        wcount = 0;
        for (int k = 0; k < tr.size(); k++) begin
            if (k > 0) tick();
            if (w === 1'b1) wcount++;
            check($sformatf("mvn run1 cyc%0d", k + 1), 32'(dut_vec), 32'(tr[k]));
            if (k == 1) begin
                in = 16'hD2F6;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        for (int k = 0; k < tr.size(); k++) begin
            tick();
            if (w === 1'b1) wcount++;
            s = 1'b0;
            check($sformatf("mvn run2 cyc%0d", k + 1), 32'(dut_vec), 32'(tr[k]));
        end
        check("mvn w pulses", 32'(wcount), 32'd2);
        check("mvn IR kept", 32'(sximm8), 32'h0000FFA3);
        tick();
        check("mvn stays idle", 32'(dut_vec), 32'(idle_rec));

        // Illegal word, then the next start clears err.
        exec_instr("ill", 16'h0000, 1'b1);
        exec_instr("after ill", 16'hA902, 1'b1);

        // Randomized instructions against the trace model.
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 7);
            opc = (r < 3) ? 3'b101 : (r < 6) ? 3'b110 : 3'($urandom_range(0, 7));
            word = {opc, 13'($urandom)};
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in = 16'($urandom);
                    ir_model = in;
                    load = 1'b1;
                end else begin
                    load = 1'b0;
                end
                tick();
                load = 1'b0;
                check($sformatf("rnd gap %0d", it), 32'(dut_vec), 32'(idle_rec));
                check($sformatf("rnd gap err %0d", it), 32'(err), 32'(err_exp));
            end
            exec_instr($sformatf("rnd%0d", it), word, ($urandom_range(0, 4) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle instruction sequencer that drives the ALU datapath. Holds a 16-bit instruction register, decodes MOV/ADD/CMP/AND/MVN, and steps a Moore FSM that issues register-file reads and writes, operand-register loads, ALU operation select, and result/status loads. It sits between instruction fetch and the datapath; `s`/`w` form the start/idle handshake with the fetch side.

## Interface
Parameters:
- none

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `s`  in  1  start; level-sampled in WAIT
- `load`  in  1  capture `in` into IR
- `in`  in  16  instruction word
- `w`  out  1  high when idle (WAIT state)
- `rnum`  out  3  register index for the read/write port
- `write`  out  1  register-file write strobe
- `vsel`  out  1  write-data select: 0 = C register, 1 = `sximm8`
- `loada`, `loadb`, `loadc`, `loads`  out  1 each  load A, B, C, status (Z/N/V)
- `asel`  out  1  1 = ALU A input forced to 0
- `bsel`  out  1  reserved, always 0
- `ALUop`  out  2  00 add, 01 sub, 10 and, 11 not-B
- `shift`  out  2  shifter control for B
- `sximm8`  out  16  IR[7:0] sign-extended, combinational from IR
- `err`  out  1  illegal-instruction flag (see Configuration)

## Operation
- Decode fields: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- Legal instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm,sh
  - 101/00 ADD Rd,Rn,Rm,sh
  - 101/01 CMP Rn,Rm,sh
  - 101/10 AND Rd,Rn,Rm,sh
  - 101/11 MVN Rd,Rm,sh
  - All other encodings are illegal.
- States: WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM. All outputs are Moore; any output not listed for a state is 0.
- WAIT: `w`=1. If `s`=1 → DECODE, else stay.
- DECODE: no strobes. Next state by instruction:
  - MOV imm → WR_IMM
  - MOV reg, MVN → GET_B
  - ADD, CMP, AND → GET_A
  - illegal → WAIT
- GET_A: `rnum`=Rn, `loada`=1 → GET_B.
- GET_B: `rnum`=Rm, `loadb`=1 → EXEC.
- EXEC: `shift`=sh; `asel`=1 only for MOV reg.
  - `ALUop`: MOV reg 00, ADD 00, CMP 01, AND 10, MVN 11.
  - CMP: `loads`=1, `loadc`=0 → WAIT.
  - All others: `loadc`=1 → WR_REG.
- WR_REG: `rnum`=Rd, `vsel`=0, `write`=1 → WAIT.
- WR_IMM: `rnum`=Rn, `vsel`=1, `write`=1 → WAIT.
- `shift` is 0 outside EXEC.
- IR: loads `in` only when `load`=1 and state is WAIT. `load` in any other state is ignored, so the decode stays stable through execution.

## Timing
- Reset (synchronous): state=WAIT, IR=0, `err`=0. After the reset edge, `w`=1 and all strobes are 0. `sximm8`=0.
- Reset asserted mid-instruction: abort at that edge; no further strobes. Writes already issued stand.
- `s` is sampled at edge T while in WAIT. DECODE occupies T+1. Latency from the `s` edge to `w` high again:
  - MOV imm: 3 cycles (WR_IMM at T+2, `w` at T+3)
  - MOV reg, MVN: 5 cycles
  - ADD, AND: 6 cycles
  - CMP: 5 cycles
  - illegal: 2 cycles
- `load` and `s` asserted in the same WAIT cycle: IR takes the new word, and DECODE uses it.
- `s` held high: a new instruction starts on the first cycle back in WAIT. `w` pulses high for exactly 1 cycle between instructions.
- `write` is high for exactly one cycle per writing instruction. CMP never writes.

## Configuration
- `ALU_SEQ_ILLEGAL_EN` defined:
  - Illegal decode sets `err`=1 at the DECODE→WAIT edge.
  - `err` stays set until the next accepted `s` (cleared at the WAIT→DECODE edge) or `reset`.
- Not defined: `err` is tied to 0. Illegal encodings still take DECODE → WAIT with no strobes.

## Test plan
- Reset then idle: `w`=1 and all strobes 0 for 10 cycles. Assert `reset` during EXEC of ADD → the next cycle is WAIT and no `write` is issued.
- `in`=16'hD2F6 (MOV R2,#-10), `load`+`s` in the same cycle → `write`=1 exactly at T+2 with `rnum`=2, `vsel`=1, `sximm8`=16'hFFF6; `w`=1 at T+3.
- `in`=16'hA0E9 (ADD R7,R0,R1,LSL#1) → sequence GET_A `rnum`=0, GET_B `rnum`=1, EXEC `ALUop`=00 `shift`=01 `loadc`=1, WR_REG `rnum`=7 `write`=1. Total latency 6 cycles.
- `in`=16'hA902 (CMP R1,R2) → EXEC `ALUop`=01 `loads`=1 `loadc`=0; `write` is never asserted; `w` high after 5 cycles.
- `in`=16'hB8A3 (MVN R5,R3) with `s` held high → GET_A is skipped, `ALUop`=11. `w` is high for exactly 1 cycle, then the instruction re-executes. Pulsing `load` with a new word mid-execution leaves IR unchanged.
- `in`=16'h0000 (illegal) → 2-cycle return to WAIT with no strobes. `err`=1 only when `ALU_SEQ_ILLEGAL_EN` is defined, and it clears on the next `s`.
